// File: rtl/tank_ai_ctrl.sv
// tank_ai_ctrl: autonomous command generator for one enemy tank.
// Drives one-hot move and shoot requests into a tank instance from a
// random walk (16-bit Galois LFSR) and reacts to its wall and death flags.
// Optional feature macro: TANK_AI_AIM_EN (turns steer toward the player).
//
// Ports:
//   clk_i, reset_ni        clock, asynchronous active-low reset
//   move_tick_i            one-cycle enable per movement step
//   wall_top_i/bottom/right/left_i  collision flags from the tank
//   tank_die_i             tank destroyed (level)
//   bullet_busy_i          this tank's bullet is in flight
//   self_x_i/self_y_i, player_x_i/player_y_i  positions (aim mode only)
//   tank_move_o            0001 down, 0010 up, 0100 right, 1000 left, 0 stop
//   tank_shoot_o           single-cycle fire request
//   state_o                current FSM state (debug)
module tank_ai_ctrl #(
   parameter logic [15:0] LFSR_SEED     = 16'hACE1,
   parameter logic [3:0]  DIR_INIT      = 4'b0010,
   parameter logic [7:0]  MIN_SEG       = 8'd16,
   parameter logic [7:0]  PAUSE_TICKS   = 8'd4,
   parameter logic [7:0]  SPAWN_DELAY   = 8'd60,
   parameter logic [7:0]  FIRE_INTERVAL = 8'd90
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic       move_tick_i,
   input  logic       wall_top_i,
   input  logic       wall_bottom_i,
   input  logic       wall_right_i,
   input  logic       wall_left_i,
   input  logic       tank_die_i,
   input  logic       bullet_busy_i,
   input  logic [9:0] self_x_i,
   input  logic [9:0] self_y_i,
   input  logic [9:0] player_x_i,
   input  logic [9:0] player_y_i,
   output logic [3:0] tank_move_o,
   output logic       tank_shoot_o,
   output logic [2:0] state_o
);

   localparam int unsigned CNT_W  = 8;
   localparam int unsigned DIR_W  = 4;
   localparam int unsigned ST_W   = 3;
   localparam int unsigned LFSR_W = 16;

   localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

   localparam logic [ST_W-1:0] ST_SPAWN = 3'd0;
   localparam logic [ST_W-1:0] ST_MOVE  = 3'd1;
   localparam logic [ST_W-1:0] ST_TURN  = 3'd2;
   localparam logic [ST_W-1:0] ST_PAUSE = 3'd3;
   localparam logic [ST_W-1:0] ST_DEAD  = 3'd4;

   localparam logic [DIR_W-1:0] DIR_DOWN  = 4'b0001;
   localparam logic [DIR_W-1:0] DIR_UP    = 4'b0010;
   localparam logic [DIR_W-1:0] DIR_RIGHT = 4'b0100;
   localparam logic [DIR_W-1:0] DIR_LEFT  = 4'b1000;

   logic [ST_W-1:0]   state_q, state_d;
   logic [DIR_W-1:0]  dir_q, dir_d;
   logic [DIR_W-1:0]  move_d;
   logic [DIR_W-1:0]  rand_dir, cand_dir, turn_dir;
   logic [DIR_W-1:0]  walls;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  seg_q, seg_d, seg_len;
   logic [CNT_W-1:0]  fire_q, fire_d, fire_inc;
   logic [CNT_W:0]    cnt_inc;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   logic              shoot_d;
   logic              fire_en;
   logic              dir_blocked, cand_blocked;

   // Clockwise rotation: up -> right -> down -> left -> up.
   function automatic logic [DIR_W-1:0] rotate_cw(input logic [DIR_W-1:0] d);
      logic [DIR_W-1:0] r;
      case (d)
         DIR_UP:    r = DIR_RIGHT;
         DIR_RIGHT: r = DIR_DOWN;
         DIR_DOWN:  r = DIR_LEFT;
         default:   r = DIR_UP;
      endcase
      return r;
   endfunction

   // Wall flags packed in the same bit order as the one-hot direction code.
   assign walls        = {wall_left_i, wall_right_i, wall_top_i, wall_bottom_i};
   assign dir_blocked  = |(dir_q & walls);
   assign cand_blocked = |(cand_dir & walls);

   // Galois step; a non-zero seed never reaches zero.
   assign lfsr_d   = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_MASK : '0);
   assign seg_len  = MIN_SEG + {3'b000, lfsr_q[4:0]};
   assign rand_dir = DIR_DOWN << lfsr_q[1:0];
   assign cnt_inc  = {1'b0, cnt_q} + 9'd1;

`ifdef TANK_AI_AIM_EN
   logic signed [10:0] dx, dy;
   logic        [10:0] adx, ady;

   // Aim: line up on the player's column first, then on its row.
   always_comb begin
      dx       = $signed({1'b0, self_x_i}) - $signed({1'b0, player_x_i});
      dy       = $signed({1'b0, self_y_i}) - $signed({1'b0, player_y_i});
      adx      = dx[10] ? 11'(-dx) : 11'(dx);
      ady      = dy[10] ? 11'(-dy) : 11'(dy);
      cand_dir = rand_dir;
      if (adx < 11'd16) begin
         cand_dir = (player_y_i > self_y_i) ? DIR_DOWN : DIR_UP;
      end else if (ady < 11'd16) begin
         cand_dir = (player_x_i > self_x_i) ? DIR_RIGHT : DIR_LEFT;
      end
   end
`else
   logic unused_pos;
   assign unused_pos = ^{self_x_i, self_y_i, player_x_i, player_y_i};
   assign cand_dir   = rand_dir;
`endif

   // Only re-picking the blocked current direction forces a rotation.
   assign turn_dir = ((cand_dir == dir_q) && cand_blocked) ? rotate_cw(cand_dir) : cand_dir;

   // State and output registers.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q      <= ST_SPAWN;
         dir_q        <= DIR_INIT;
         cnt_q        <= '0;
         seg_q        <= '0;
         fire_q       <= '0;
         lfsr_q       <= LFSR_SEED;
         tank_move_o  <= '0;
         tank_shoot_o <= 1'b0;
      end else begin
         state_q      <= state_d;
         dir_q        <= dir_d;
         cnt_q        <= cnt_d;
         seg_q        <= seg_d;
         fire_q       <= fire_d;
         lfsr_q       <= lfsr_d;
         tank_move_o  <= move_d;
         tank_shoot_o <= shoot_d;
      end
   end

   assign state_o = state_q;

   // Next-state, counters and next outputs.
   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      cnt_d    = cnt_q;
      seg_d    = seg_q;
      fire_d   = fire_q;
      fire_inc = fire_q;
      fire_en  = 1'b0;
      shoot_d  = 1'b0;
      move_d   = '0;

      case (state_q)
         ST_SPAWN: begin
            if (move_tick_i) begin
               if (cnt_inc >= {1'b0, SPAWN_DELAY}) begin
                  state_d = ST_MOVE;
                  dir_d   = DIR_INIT;
                  seg_d   = seg_len;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc[CNT_W-1:0];
               end
            end
         end
         ST_MOVE: begin
            if (move_tick_i) begin
               fire_en = 1'b1;
               if (dir_blocked) begin
                  state_d = ST_TURN;
               end else if (seg_q <= 8'd1) begin
                  state_d = ST_TURN;
                  seg_d   = '0;
               end else begin
                  seg_d = seg_q - 8'd1;
               end
            end
         end
         ST_TURN: begin
            state_d = ST_PAUSE;
            dir_d   = turn_dir;
            cnt_d   = '0;
         end
         ST_PAUSE: begin
            if (move_tick_i) begin
               fire_en = 1'b1;
               if (cnt_inc >= {1'b0, PAUSE_TICKS}) begin
                  state_d = ST_MOVE;
                  seg_d   = seg_len;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc[CNT_W-1:0];
               end
            end
         end
         ST_DEAD: begin
            if (!tank_die_i) begin
               state_d = ST_SPAWN;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_SPAWN;
            cnt_d   = '0;
         end
      endcase

      // Fire counter saturates; the idle-before-pulse guard keeps pulses separated.
      if (fire_en && (fire_q < FIRE_INTERVAL)) begin
         fire_inc = fire_q + 8'd1;
      end
      if (state_q == ST_DEAD) begin
         fire_d = '0;
      end else if ((fire_inc >= FIRE_INTERVAL) && !bullet_busy_i && !tank_shoot_o) begin
         shoot_d = 1'b1;
         fire_d  = '0;
      end else begin
         fire_d = fire_inc;
      end

      // Death overrides every other transition.
      if (tank_die_i) begin
         state_d = ST_DEAD;
         cnt_d   = '0;
         fire_d  = '0;
         shoot_d = 1'b0;
      end

      move_d = (state_d == ST_MOVE) ? dir_d : '0;
   end

endmodule

// File: tb/tb_tank_ai_ctrl.sv
// Bench for tank_ai_ctrl: a cycle model predicts each output triple, pushes it
// to a scoreboard when inputs are driven, and a monitor pops and compares it
// one cycle later. Directed checks cover the key scenarios.
module tb_tank_ai_ctrl;

   localparam logic [15:0] SEED   = 16'hACE1;
   localparam logic [3:0]  DIR0   = 4'b0010;
   localparam int          MIN_SEG_T = 16;
   localparam int          PAUSE_T   = 4;
   localparam int          SPAWN_T   = 60;
   localparam int          FIRE_T    = 10;

   localparam logic [2:0] S_SPAWN = 3'd0;
   localparam logic [2:0] S_MOVE  = 3'd1;
   localparam logic [2:0] S_TURN  = 3'd2;
   localparam logic [2:0] S_PAUSE = 3'd3;
   localparam logic [2:0] S_DEAD  = 3'd4;

   typedef struct {
      logic [3:0] mv;
      logic       sh;
      logic [2:0] st;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       move_tick = 1'b0;
   logic       wall_top = 1'b0, wall_bottom = 1'b0, wall_right = 1'b0, wall_left = 1'b0;
   logic       die = 1'b0, busy = 1'b0;
   logic [9:0] self_x = 10'd0, self_y = 10'd0, player_x = 10'd500, player_y = 10'd500;
   logic [3:0] tank_move;
   logic       tank_shoot;
   logic [2:0] state;

   int n_checks = 0;
   int n_fail   = 0;
   int pulse_cnt = 0;
   logic shoot_prev = 1'b0;

   exp_t sb_q[$];
   exp_t mon_e;

   // Reference model state
   logic [15:0] m_lfsr;
   logic [2:0]  m_state;
   logic [3:0]  m_dir;
   int          m_cnt, m_seg, m_fire;
   logic        m_shoot;

   always #5 clk = ~clk;

   tank_ai_ctrl #(
      .LFSR_SEED    (SEED),
      .DIR_INIT     (DIR0),
      .MIN_SEG      (8'(MIN_SEG_T)),
      .PAUSE_TICKS  (8'(PAUSE_T)),
      .SPAWN_DELAY  (8'(SPAWN_T)),
      .FIRE_INTERVAL(8'(FIRE_T))
   ) dut (
      .clk_i        (clk),
      .reset_ni     (reset_n),
      .move_tick_i  (move_tick),
      .wall_top_i   (wall_top),
      .wall_bottom_i(wall_bottom),
      .wall_right_i (wall_right),
      .wall_left_i  (wall_left),
      .tank_die_i   (die),
      .bullet_busy_i(busy),
      .self_x_i     (self_x),
      .self_y_i     (self_y),
      .player_x_i   (player_x),
      .player_y_i   (player_y),
      .tank_move_o  (tank_move),
      .tank_shoot_o (tank_shoot),
      .state_o      (state)
   );

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // LFSR model: x^16+x^14+x^13+x^11+1, right-shifting Galois form.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) m_lfsr <= SEED;
      else if (m_lfsr[0]) m_lfsr <= (m_lfsr >> 1) ^ 16'hB400;
      else m_lfsr <= m_lfsr >> 1;
   end

   // Monitor: compare the prediction for the edge just taken.
   always @(posedge clk) begin
      #1;
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         check_eq("sb_move", 16'(tank_move), 16'(mon_e.mv));
         check_eq("sb_shoot", 16'(tank_shoot), 16'(mon_e.sh));
         check_eq("sb_state", 16'(state), 16'(mon_e.st));
      end
      if (tank_shoot && !shoot_prev) pulse_cnt++;
      shoot_prev = tank_shoot;
   end

   function automatic logic blocked(input logic [3:0] d);
      case (d)
         4'b0001: return wall_bottom;
         4'b0010: return wall_top;
         4'b0100: return wall_right;
         4'b1000: return wall_left;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] cw(input logic [3:0] d);
      case (d)
         4'b0010: return 4'b0100;
         4'b0100: return 4'b0001;
         4'b0001: return 4'b1000;
         default: return 4'b0010;
      endcase
   endfunction

   function automatic logic [3:0] pick_dir();
      logic [3:0] d;
`ifdef TANK_AI_AIM_EN
      int dx, dy;
`endif
      case (m_lfsr[1:0])
         2'd0:    d = 4'b0001;
         2'd1:    d = 4'b0010;
         2'd2:    d = 4'b0100;
         default: d = 4'b1000;
      endcase
`ifdef TANK_AI_AIM_EN
      dx = int'(self_x) - int'(player_x);
      dy = int'(self_y) - int'(player_y);
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      if (dx < 16) d = (player_y > self_y) ? 4'b0001 : 4'b0010;
      else if (dy < 16) d = (player_x > self_x) ? 4'b0100 : 4'b1000;
`endif
      return d;
   endfunction

   task automatic model_reset();
      m_state = S_SPAWN;
      m_dir   = DIR0;
      m_cnt   = 0;
      m_seg   = 0;
      m_fire  = 0;
      m_shoot = 1'b0;
   endtask

   // One cycle: drive inputs at negedge, predict, push, advance.
   task automatic step(input logic tick);
      logic [2:0] st0;
      logic       cnt_en;
      logic       sh;
      logic [3:0] cand;
      exp_t       e;
      move_tick = tick;
      st0    = m_state;
      cnt_en = 1'b0;
      sh     = 1'b0;
      if (die) begin
         m_state = S_DEAD;
         m_cnt   = 0;
         m_fire  = 0;
      end else begin
         case (m_state)
            S_SPAWN: if (tick) begin
               m_cnt++;
               if (m_cnt == SPAWN_T) begin
                  m_state = S_MOVE;
                  m_dir   = DIR0;
                  m_seg   = MIN_SEG_T + int'(m_lfsr[4:0]);
                  m_cnt   = 0;
               end
            end
            S_MOVE: if (tick) begin
               cnt_en = 1'b1;
               if (blocked(m_dir)) m_state = S_TURN;
               else begin
                  m_seg--;
                  if (m_seg <= 0) m_state = S_TURN;
               end
            end
            S_TURN: begin
               cand = pick_dir();
               if (cand == m_dir && blocked(cand)) cand = cw(cand);
               m_dir   = cand;
               m_state = S_PAUSE;
               m_cnt   = 0;
            end
            S_PAUSE: if (tick) begin
               cnt_en = 1'b1;
               m_cnt++;
               if (m_cnt == PAUSE_T) begin
                  m_state = S_MOVE;
                  m_seg   = MIN_SEG_T + int'(m_lfsr[4:0]);
                  m_cnt   = 0;
               end
            end
            default: begin
               m_fire  = 0;
               m_state = S_SPAWN;
               m_cnt   = 0;
            end
         endcase
         if (cnt_en && m_fire < FIRE_T) m_fire++;
         if (st0 != S_DEAD && m_fire >= FIRE_T && !busy && !m_shoot) begin
            sh     = 1'b1;
            m_fire = 0;
         end
      end
      m_shoot = sh;
      e.mv = (m_state == S_MOVE) ? m_dir : 4'b0000;
      e.sh = sh;
      e.st = m_state;
      sb_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic tick_run(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b1);
         step(1'b0);
         step(1'b0);
         step(1'b0);
      end
   endtask

   task automatic run_until(input logic [2:0] st, input int limit, input string tag);
      for (int i = 0; i < limit; i++) begin
         if (m_state == st) break;
         tick_run(1);
      end
      check_eq(tag, 16'(state), 16'(st));
   endtask

   initial begin
      model_reset();
      #12;
      check_eq("rst_move", 16'(tank_move), 16'h0);
      check_eq("rst_shoot", 16'(tank_shoot), 16'h0);
      check_eq("rst_state", 16'(state), 16'(S_SPAWN));
      @(negedge clk);
      reset_n = 1'b1;

      // Spawn delay then first move up.
      tick_run(SPAWN_T - 1);
      check_eq("spawn_still", 16'(tank_move), 16'h0);
      step(1'b1);
      check_eq("spawn_move", 16'(tank_move), 16'(DIR0));
      check_eq("spawn_state", 16'(state), 16'(S_MOVE));
      step(1'b0); step(1'b0); step(1'b0);

      // Periodic fire: one pulse per FIRE_T ticks.
      begin
         int p0;
         p0 = pulse_cnt;
         tick_run(4 * FIRE_T);
         check_eq("fire_pulses", 16'(pulse_cnt - p0), 16'd4);
      end

      // Busy bullet holds the shot until released.
      begin
         int p0;
         busy = 1'b1;
         p0 = pulse_cnt;
         tick_run(25);
         check_eq("busy_no_pulse", 16'(pulse_cnt - p0), 16'd0);
         busy = 1'b0;
         step(1'b0);
         check_eq("busy_release_shot", 16'(tank_shoot), 16'h1);
         step(1'b0);
         check_eq("busy_shot_width", 16'(tank_shoot), 16'h0);
      end

      // Wall in the travel direction forces a turn away from it.
      for (int i = 0; i < 1500; i++) begin
         if (m_state == S_MOVE && m_dir == 4'b0100) break;
         tick_run(1);
      end
      check_eq("find_right", 16'(tank_move), 16'h4);
      wall_right = 1'b1;
      step(1'b1);
      check_eq("wall_stop", 16'(tank_move), 16'h0);
      check_eq("wall_turn_state", 16'(state), 16'(S_TURN));
      step(1'b0);
      wall_right = 1'b0;
      step(1'b0); step(1'b0);
      tick_run(PAUSE_T);
      check_eq("wall_resume_state", 16'(state), 16'(S_MOVE));
      check_eq("wall_dir_not_right", 16'(tank_move == 4'b0100), 16'h0);

      // Death during MOVE, then respawn.
      die = 1'b1;
      step(1'b0);
      check_eq("die_state", 16'(state), 16'(S_DEAD));
      check_eq("die_move", 16'(tank_move), 16'h0);
      check_eq("die_shoot", 16'(tank_shoot), 16'h0);
      step(1'b1); step(1'b0);
      die = 1'b0;
      step(1'b0);
      check_eq("respawn_state", 16'(state), 16'(S_SPAWN));
      tick_run(SPAWN_T);
      check_eq("respawn_dir", 16'(tank_move), 16'(DIR0));
      check_eq("respawn_state_move", 16'(state), 16'(S_MOVE));

`ifdef TANK_AI_AIM_EN
      // Aim: player nearly in the same column and above.
      self_x = 10'd100; self_y = 10'd200; player_x = 10'd104; player_y = 10'd50;
      run_until(S_PAUSE, 200, "aim_reach_pause");
      run_until(S_MOVE, 20, "aim_reach_move");
      check_eq("aim_up", 16'(tank_move), 16'h2);
      wall_top = 1'b1;
      tick_run(1);
      wall_top = 1'b0;
      run_until(S_MOVE, 20, "aim_wall_move");
      check_eq("aim_wall_right", 16'(tank_move), 16'h4);
      self_x = 10'd0; self_y = 10'd0; player_x = 10'd500; player_y = 10'd500;
`endif

      // Reset asserted while a shot pulse is high.
      for (int i = 0; i < 2000; i++) begin
         step(1'(i % 4 == 0));
         if (m_shoot) break;
      end
      check_eq("shot_before_reset", 16'(tank_shoot), 16'h1);
      reset_n = 1'b0;
      #1;
      check_eq("async_rst_shoot", 16'(tank_shoot), 16'h0);
      check_eq("async_rst_move", 16'(tank_move), 16'h0);
      check_eq("async_rst_state", 16'(state), 16'(S_SPAWN));
      sb_q.delete();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      tick_run(SPAWN_T + 2);
      check_eq("post_rst_move", 16'(tank_move), 16'(DIR0));

      @(posedge clk);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
